// File: rtl/pipeline_stage_reg.sv
// Inter-stage pipeline register: control + data fields, valid/ready handshake,
// hazard stall/flush, and an optional skid entry that registers in_ready.
module pipeline_stage_reg #(
    parameter int                    CTRL_WIDTH = 8,
    parameter int                    DATA_WIDTH = 160,
    parameter logic [CTRL_WIDTH-1:0] CTRL_NOP   = '0,
    parameter bit                    SKID       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [DATA_WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

    state_t                state_reg, state_next;
    logic [CTRL_WIDTH-1:0] main_ctrl_reg, skid_ctrl_reg;
    logic [DATA_WIDTH-1:0] main_data_reg, skid_data_reg;
    logic                  accept, emit;
    logic                  load_main_in, load_main_skid, load_skid;

    // With the skid entry, in_ready depends only on state and stall, never on out_ready.
    generate
        if (SKID) begin : g_skid
            assign in_ready = (state_reg != ST_TWO) & ~stall;
        end else begin : g_noskid
            assign in_ready = ((state_reg == ST_EMPTY) | out_ready) & ~stall;
        end
    endgenerate

    assign accept = in_valid & in_ready;
    assign emit   = (state_reg != ST_EMPTY) & out_ready & ~stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: if (accept) state_next = ST_ONE;
                ST_ONE: begin
                    if (accept && !emit)      state_next = SKID ? ST_TWO : ST_ONE;
                    else if (emit && !accept) state_next = ST_EMPTY;
                end
                ST_TWO:   if (emit) state_next = ST_ONE;
                default:  state_next = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (!flush) begin
            case (state_reg)
                ST_EMPTY: load_main_in = accept;
                ST_ONE: begin
                    load_main_in = accept & emit;
                    load_skid    = accept & ~emit;
                end
                ST_TWO:   load_main_skid = emit;
                default:  load_main_in = 1'b0;
            endcase
        end
        out_valid = (state_reg != ST_EMPTY);
        // Bubble guarantee: stale control bits never leak while invalid.
        out_ctrl  = out_valid ? main_ctrl_reg : CTRL_NOP;
        out_data  = main_data_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_ctrl_reg <= CTRL_NOP;
            main_data_reg <= '0;
        end else if (load_main_in) begin
            main_ctrl_reg <= in_ctrl;
            main_data_reg <= in_data;
        end else if (load_main_skid) begin
            main_ctrl_reg <= skid_ctrl_reg;
            main_data_reg <= skid_data_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_ctrl_reg <= CTRL_NOP;
            skid_data_reg <= '0;
        end else if (load_skid) begin
            skid_ctrl_reg <= in_ctrl;
            skid_data_reg <= in_data;
        end
    end

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Bench for pipeline_stage_reg: drives a SKID=1 and a SKID=0 instance with the
// same inputs and checks both against a FIFO-level reference model.
module tb_pipeline_stage_reg;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, stall, flush, out_ready;
    logic [7:0]   in_ctrl;
    logic [159:0] in_data;
    logic [1:0]   ir, ov;
    logic [7:0]   oc0, oc1;
    logic [159:0] od0, od1;

    int checks = 0;
    int errors = 0;

    // model: per instance a small FIFO (capacity 2 or 1) plus the last shown data
    logic [7:0]   mc [2][2];
    logic [159:0] md [2][2];
    int           mn [2] = '{0, 0};
    logic [159:0] ms [2] = '{160'd0, 160'd0};

    always #5 clk = ~clk;

    pipeline_stage_reg #(.SKID(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .in_ctrl(in_ctrl), .in_data(in_data), .stall(stall), .flush(flush),
        .out_valid(ov[0]), .out_ready(out_ready), .out_ctrl(oc0), .out_data(od0)
    );

    pipeline_stage_reg #(.SKID(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .in_ctrl(in_ctrl), .in_data(in_data), .stall(stall), .flush(flush),
        .out_valid(ov[1]), .out_ready(out_ready), .out_ctrl(oc1), .out_data(od1)
    );

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare process: mid-cycle, check both instances, then advance the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int k = 0; k < 2; k++) begin
                    mn[k] = 0;
                    ms[k] = '0;
                end
                chk("rst_out_valid", {158'd0, ov}, 160'd0);
                chk("rst_out_data", od0 | od1, 160'd0);
            end else begin
                for (int k = 0; k < 2; k++) begin
                    logic rdy, acc, emt;
                    rdy = (k == 0) ? (mn[k] < 2 && !stall)
                                   : ((mn[k] == 0 || out_ready) && !stall);
                    chk($sformatf("in_ready%0d", k), {159'd0, ir[k]}, {159'd0, rdy});
                    chk($sformatf("out_valid%0d", k), {159'd0, ov[k]}, {159'd0, mn[k] > 0});
                    chk($sformatf("out_ctrl%0d", k), {152'd0, (k == 0) ? oc0 : oc1},
                        {152'd0, (mn[k] > 0) ? mc[k][0] : 8'h00});
                    chk($sformatf("out_data%0d", k), (k == 0) ? od0 : od1, ms[k]);
                    acc = in_valid && rdy;
                    emt = (mn[k] > 0) && out_ready && !stall;
                    if (flush) begin
                        mn[k] = 0;
                    end else begin
                        if (emt) begin
                            $display("emit inst%0d ctrl=%h data=%h", k, mc[k][0], md[k][0]);
                            mc[k][0] = mc[k][1];
                            md[k][0] = md[k][1];
                            mn[k]--;
                        end
                        if (acc) begin
                            mc[k][mn[k]] = in_ctrl;
                            md[k][mn[k]] = in_data;
                            mn[k]++;
                        end
                    end
                    if (mn[k] > 0) ms[k] = md[k][0];
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        #2;
        chk("reset_valid", {158'd0, ov}, 160'd0);
        chk("reset_ctrl", {152'd0, oc0}, 160'd0);
        chk("reset_data", od0, 160'd0);
        chk("reset_ready", {158'd0, ir}, 160'd3);
        tick();
        rst_n = 1'b1;
        tick();

        // streaming
        out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 8'h01;
        for (int i = 0; i < 3; i++) begin
            in_data = 160'h10 + 160'(i);
            tick();
            chk("stream_data", od0, 160'h10 + 160'(i));
            chk("stream_ready", {159'd0, ir[0]}, 160'd1);
        end
        in_valid = 1'b0;
        tick();

        // backpressure
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h5A; in_data = 160'hA;
        tick();
        chk("bp_noskid_ready", {159'd0, ir[1]}, 160'd0);
        in_data = 160'hB;
        tick();
        chk("bp_two_ready", {159'd0, ir[0]}, 160'd0);
        chk("bp_two_head", od0, 160'hA);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("noskid_comb_ready", {159'd0, ir[1]}, 160'd1);
        tick();
        chk("bp_second", od0, 160'hB);
        tick();
        chk("bp_drained", {158'd0, ov}, 160'd0);

        // flush in TWO with an incoming instruction
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h5A; in_data = 160'h1;
        tick();
        in_data = 160'h2;
        tick();
        chk("two_ctrl", {152'd0, oc0}, 160'h5A);
        in_ctrl = 8'h33; in_data = 160'hC; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", {159'd0, ov[0]}, 160'd0);
        chk("flush_ctrl", {152'd0, oc0}, 160'd0);
        chk("flush_ready", {159'd0, ir[0]}, 160'd1);
        chk("flush_data_kept", od0, 160'h1);
        out_ready = 1'b1;
        repeat (3) begin
            tick();
            chk("flush_no_emit", {159'd0, ov[0]}, 160'd0);
        end

        // stall, then stall + flush
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h11; in_data = 160'hA;
        tick();
        in_valid = 1'b0; stall = 1'b1; out_ready = 1'b1;
        repeat (3) begin
            tick();
            chk("stall_data", od0, 160'hA);
            chk("stall_ctrl", {152'd0, oc0}, 160'h11);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0; stall = 1'b0;
        chk("stall_flush_valid", {158'd0, ov}, 160'd0);

        // async reset between edges while in TWO
        out_ready = 1'b0; in_valid = 1'b1; in_data = 160'h55;
        tick();
        in_data = 160'h66;
        tick();
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("async_valid", {159'd0, ov[0]}, 160'd0);
        chk("async_data", od0, 160'd0);
        tick();
        rst_n = 1'b1;
        tick();
        in_valid = 1'b1; in_data = 160'h77; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post_reset_data", od0, 160'h77);
        chk("post_reset_valid", {159'd0, ov[0]}, 160'd1);
        tick();

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_ctrl   = 8'($urandom);
            in_data   = {$urandom, $urandom, $urandom, $urandom, $urandom};
            stall     = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
